// File: rtl/alu_pkg.sv
// Shared types and select encodings for the ALU issue queue.
package alu_pkg;

    localparam logic [3:0] ALU_SEL_AND = 4'b0000;
    localparam logic [3:0] ALU_SEL_OR  = 4'b0001;
    localparam logic [3:0] ALU_SEL_XOR = 4'b0010;
    localparam logic [3:0] ALU_SEL_ADD = 4'b0011;

    localparam int ALU_LATENCY = 1;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
    } alu_cmd_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  sel;
    } alu_res_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a synchronous clear.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[IW] != rptr[IW]) && (wptr[IW-1:0] == rptr[IW-1:0]);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign rdata   = mem[rptr[IW-1:0]];
    assign count   = CW'(wptr - rptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (clear) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (do_push) begin
                    mem[wptr[IW-1:0]] <= wdata;
                    wptr              <= wptr + PW'(1);
                end
                if (do_pop) begin
                    rptr <= rptr + PW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/alu_cmd_queue.sv
// Issue stage for a one-cycle registered ALU: buffers commands, issues them
// with result-slot credits, and captures tagged results for the consumer.
module alu_cmd_queue
    import alu_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4,
    parameter int AW        = $clog2((CMD_DEPTH > RES_DEPTH) ? CMD_DEPTH : RES_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_a,
    input  logic [31:0]   in_b,
    input  logic [3:0]    in_sel,
    output logic [31:0]   alu_a,
    output logic [31:0]   alu_b,
    output logic [3:0]    alu_sel,
    output logic          alu_issue,
    input  logic [31:0]   alu_out,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [31:0]   res_data,
    output logic [3:0]    res_sel,
    output logic [AW-1:0] cmd_count
);

    alu_cmd_t      cmd_wdata;
    alu_cmd_t      cmd_head;
    logic          cmd_full;
    logic          cmd_empty;
    alu_res_t      res_wdata;
    alu_res_t      res_head;
    logic          res_full;
    logic          res_empty;
    logic [AW-1:0] res_count;
    logic          s1_valid;
    logic [3:0]    s1_sel;
    logic          s2_valid;
    logic [3:0]    s2_sel;
    logic [AW:0]   in_flight;
    logic          credit_ok;
    logic          issue;
    logic          cmd_push;
    logic          res_push;
    logic          res_pop;

    assign cmd_wdata = '{a: in_a, b: in_b, sel: in_sel};
    assign in_ready  = !cmd_full;
    assign cmd_push  = in_valid && in_ready && !flush;

    // Every op past the command FIFO owns a result slot, so capture never overflows.
    assign in_flight = (AW+1)'(s1_valid) + (AW+1)'(s2_valid) + (AW+1)'(res_count);
    assign credit_ok = in_flight < (AW+1)'(RES_DEPTH);
    assign issue     = !cmd_empty && credit_ok && !flush;

    assign res_wdata = '{data: alu_out, sel: s2_sel};
    assign res_push  = s2_valid && !flush && !res_full;
    assign res_pop   = !res_empty && res_ready;
    assign res_valid = !res_empty;
    assign res_data  = res_head.data;
    assign res_sel   = res_head.sel;

    sync_fifo #(.WIDTH($bits(alu_cmd_t)), .DEPTH(CMD_DEPTH), .CW(AW)) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (cmd_push),
        .pop   (issue),
        .wdata (cmd_wdata),
        .rdata (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count)
    );

    sync_fifo #(.WIDTH($bits(alu_res_t)), .DEPTH(RES_DEPTH), .CW(AW)) u_res_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (res_push),
        .pop   (res_pop),
        .wdata (res_wdata),
        .rdata (res_head),
        .full  (res_full),
        .empty (res_empty),
        .count (res_count)
    );

    // s1: op sits on the ALU inputs; s2: ALU has registered it and alu_out is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            alu_issue <= 1'b0;
            s1_valid  <= 1'b0;
            s1_sel    <= '0;
            s2_valid  <= 1'b0;
            s2_sel    <= '0;
        end else begin
            alu_issue <= issue;
            s1_valid  <= issue;
            s2_valid  <= s1_valid && !flush;
            s2_sel    <= s1_sel;
            if (issue) begin
                alu_a   <= cmd_head.a;
                alu_b   <= cmd_head.b;
                alu_sel <= cmd_head.sel;
                s1_sel  <= cmd_head.sel;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Scoreboard bench for alu_cmd_queue with a behavioural registered ALU.
module tb_alu_cmd_queue;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [3:0]  in_sel = '0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_sel;
    logic        alu_issue;
    logic [31:0] alu_out = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [3:0]  res_sel;
    logic [2:0]  cmd_count;

    int checks = 0;
    int errors = 0;
    int issue_cnt = 0;
    int pop_cnt = 0;
    int cyc = 0;
    logic [35:0] exp_q[$];
    int          pop_cyc[$];
    logic [35:0] mon_exp;

    alu_cmd_queue #(.CMD_DEPTH(4), .RES_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sel    (in_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_issue (alu_issue),
        .alu_out   (alu_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_sel   (res_sel),
        .cmd_count (cmd_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Registered ALU; unknown selects produce a recognisable marker.
    always @(posedge clk) begin
        case (alu_sel)
            ALU_SEL_AND: alu_out <= alu_a & alu_b;
            ALU_SEL_OR:  alu_out <= alu_a | alu_b;
            ALU_SEL_XOR: alu_out <= alu_a ^ alu_b;
            ALU_SEL_ADD: alu_out <= alu_a + alu_b;
            default:     alu_out <= 32'hBAD0_0000 | {28'h0, alu_sel};
        endcase
    end

    always @(negedge clk) begin
        if (alu_issue) issue_cnt++;
        if (rst_n && res_valid && res_ready) begin
            pop_cnt++;
            pop_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL res_unexpected actual data=%h sel=%h required none", res_data, res_sel);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({res_data, res_sel} !== mon_exp) begin
                    errors++;
                    $display("FAIL res_data actual data=%h sel=%h required data=%h sel=%h",
                             res_data, res_sel, mon_exp[35:4], mon_exp[3:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_one(input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] sel, input logic [31:0] exp);
        int n = 0;
        in_a = a;
        in_b = b;
        in_sel = sel;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("push_timeout", 64'(in_ready), 64'(1));
        end else begin
            exp_q.push_back({exp, sel});
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    logic [31:0] bp_exp [10] = '{32'h0000_0000, 32'h0000_010F, 32'h0000_010D, 32'h0000_0112,
                                 32'h0000_0004, 32'h0000_010F, 32'h0000_0109, 32'h0000_0116,
                                 32'h0000_0008, 32'h0000_010F};

    initial begin
        int acc;
        int issue_base;
        int pop_base;
        logic rdy;
        logic seen;

        #2;
        chk("rst_in_ready",  64'(in_ready), 64'(1));
        chk("rst_alu_issue", 64'(alu_issue), 64'(0));
        chk("rst_alu_a",     64'(alu_a), 64'(0));
        chk("rst_res_valid", 64'(res_valid), 64'(0));
        chk("rst_res_data",  64'(res_data), 64'(0));
        chk("rst_cmd_count", 64'(cmd_count), 64'(0));
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b1;

        // single AND with latency checks
        push_one(32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_SEL_AND, 32'h00F0_00F0);
        @(negedge clk) chk("and_issue_early", 64'(alu_issue), 64'(0));
        @(negedge clk);
        chk("and_issue", 64'(alu_issue), 64'(1));
        chk("and_alu_a", 64'(alu_a), 64'(32'hF0F0_F0F0));
        chk("and_alu_b", 64'(alu_b), 64'(32'h0FF0_0FF0));
        @(negedge clk) chk("and_res_early", 64'(res_valid), 64'(0));
        @(negedge clk) chk("and_res_valid", 64'(res_valid), 64'(1));
        wait_drain(20);

        // back-to-back, one result per cycle
        pop_cyc.delete();
        push_one(32'h5, 32'h3, ALU_SEL_AND, 32'h1);
        push_one(32'h5, 32'h3, ALU_SEL_OR,  32'h7);
        push_one(32'h5, 32'h3, ALU_SEL_XOR, 32'h6);
        push_one(32'h5, 32'h3, ALU_SEL_ADD, 32'h8);
        wait_drain(30);
        chk("b2b_count", 64'(pop_cyc.size()), 64'(4));
        if (pop_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++) chk("b2b_consecutive", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'(1));
        end

        // backpressure: 10 offered, 8 accepted, 4 issued
        res_ready = 1'b0;
        acc = 0;
        issue_base = issue_cnt;
        for (int k = 0; k < 14; k++) begin
            if (acc < 10) begin
                in_a = 32'h100 + 32'(acc);
                in_b = 32'h0F;
                in_sel = 4'(acc % 4);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk) rdy = in_ready;
            @(posedge clk);
            if (rdy && in_valid) begin
                exp_q.push_back({bp_exp[acc], 4'(acc % 4)});
                acc++;
            end
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_accepted",  64'(acc), 64'(8));
        chk("bp_issues",    64'(issue_cnt - issue_base), 64'(4));
        chk("bp_cmd_count", 64'(cmd_count), 64'(4));
        chk("bp_in_ready",  64'(in_ready), 64'(0));
        pop_base = pop_cnt;
        res_ready = 1'b1;
        @(posedge clk);
        #1 wait_drain(60);
        chk("bp_pops", 64'(pop_cnt - pop_base), 64'(8));

        // flush with ops queued, in flight and buffered
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) push_one(32'h10 + 32'(k), 32'h1, ALU_SEL_ADD, 32'h11 + 32'(k));
        flush = 1'b1;
        in_valid = 1'b1;
        in_a = 32'hDEAD_BEEF;
        in_sel = ALU_SEL_OR;
        exp_q.delete();
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_res_valid", 64'(res_valid), 64'(0));
        chk("flush_cmd_count", 64'(cmd_count), 64'(0));
        chk("flush_in_ready",  64'(in_ready), 64'(1));
        chk("flush_alu_issue", 64'(alu_issue), 64'(0));
        seen = 1'b0;
        repeat (4) @(negedge clk) if (res_valid || alu_issue) seen = 1'b1;
        chk("flush_quiet", 64'(seen), 64'(0));
        @(posedge clk);
        #1 res_ready = 1'b1;
        push_one(32'h1234_5678, 32'hFFFF_0000, ALU_SEL_XOR, 32'hEDCB_5678);
        wait_drain(20);

        // asynchronous reset with ops in flight
        push_one(32'h1, 32'h1, ALU_SEL_ADD, 32'h2);
        push_one(32'h2, 32'h2, ALU_SEL_ADD, 32'h4);
        push_one(32'h3, 32'h3, ALU_SEL_ADD, 32'h6);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_in_ready",  64'(in_ready), 64'(1));
        chk("arst_alu_issue", 64'(alu_issue), 64'(0));
        chk("arst_alu_a",     64'(alu_a), 64'(0));
        chk("arst_alu_sel",   64'(alu_sel), 64'(0));
        chk("arst_res_valid", 64'(res_valid), 64'(0));
        chk("arst_cmd_count", 64'(cmd_count), 64'(0));
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) @(negedge clk) if (res_valid || alu_issue) seen = 1'b1;
        chk("arst_no_stale", 64'(seen), 64'(0));
        @(posedge clk);
        #1;

        // ADD wrap and an undefined select passing through
        push_one(32'hFFFF_FFFF, 32'h0000_0001, ALU_SEL_ADD, 32'h0000_0000);
        push_one(32'h0000_0007, 32'h0000_0009, 4'hA, 32'hBAD0_000A);
        wait_drain(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
